// File: rtl/sram_pkg.sv
// Shared constants and lane-merge helper for the 1RW+1R SRAM family.
// Latency: none (package only).
// Backpressure: not applicable.
package sram_pkg;

  localparam int COLL_WRITE_FIRST = 0;
  localparam int COLL_READ_FIRST  = 1;

  // Widest word the merge helper handles; callers zero-extend into this width.
  localparam int SRAM_MAX_W = 256;

  // Take new_w in every lane whose mask bit is set, old_w elsewhere.
  function automatic logic [SRAM_MAX_W-1:0] lane_merge(
    input logic [SRAM_MAX_W-1:0] old_w,
    input logic [SRAM_MAX_W-1:0] new_w,
    input logic [SRAM_MAX_W-1:0] mask,
    input int                    lane_width
  );
    logic [SRAM_MAX_W-1:0] merged;
    merged = old_w;
    for (int i = 0; i < SRAM_MAX_W; i++) begin
      if (mask[i / lane_width]) merged[i] = new_w[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read return pipeline: carries a read strobe and its data to the output.
// Latency: LATENCY cycles from i_vld to o_vld.
// Backpressure: none; accepts a new entry every cycle, output holds last data.
module sram_rd_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_vld [LATENCY];
  logic [WIDTH-1:0] r_dat [LATENCY];

  // Valid shifts every cycle; data only advances behind a valid so the tail holds the last read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_vld[s] <= 1'b0;
        r_dat[s] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) r_dat[0] <= i_dat;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) r_dat[s] <= r_dat[s-1];
      end
    end
  end

  assign o_vld = r_vld[LATENCY-1];
  assign o_dat = r_dat[LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R synchronous SRAM with masked writes, collision forwarding and counter.
// Latency: READ_LATENCY (1 or 2) cycles from sampled read to dout*_valid.
// Backpressure: none; both ports accept a request every cycle.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 9,
  parameter int    LANE_WIDTH   = 8,
  parameter int    READ_LATENCY = 1,
  parameter int    COLL_MODE    = 0,
  parameter string INIT_FILE    = "",
  localparam int   NUM_WMASKS   = DATA_WIDTH / LANE_WIDTH,
  localparam int   RAM_DEPTH    = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  input  logic                  coll_clr,
  output logic                  collision,
  output logic [15:0]           coll_count
);

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_err_lane
    $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_err_lat
    $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH > SRAM_MAX_W) begin : g_err_width
    $error("sram_1rw1r_param: DATA_WIDTH exceeds lane_merge capacity");
  end

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [15:0]           r_coll_count;
  logic                  r_coll_d;

  logic                  w_wr_en;
  logic                  w_wr_go;
  logic                  w_rd0_en;
  logic                  w_rd1_en;
  logic                  w_coll;
  logic                  w_coll_inc;
  logic [DATA_WIDTH-1:0] w_rd0_dat;
  logic [DATA_WIDTH-1:0] w_rd1_old;
  logic [DATA_WIDTH-1:0] w_rd1_merged;
  logic [DATA_WIDTH-1:0] w_rd1_dat;
  logic [DATA_WIDTH:0]   w_p1_dat;

  assign w_wr_en  = ~csb0 & ~web0;
  assign w_wr_go  = w_wr_en & rst_n;
  assign w_rd0_en = ~csb0 & web0;
  assign w_rd1_en = ~csb1;

  // A zero-mask write changes nothing, so it cannot collide.
  assign w_coll = w_wr_en & (|wmask0) & w_rd1_en & (addr0 == addr1);

  // Array reads see the pre-edge contents; write-first forwarding merges the incoming lanes.
  assign w_rd0_dat    = r_mem[addr0];
  assign w_rd1_old    = r_mem[addr1];
  assign w_rd1_merged = DATA_WIDTH'(lane_merge(SRAM_MAX_W'(w_rd1_old), SRAM_MAX_W'(din0),
                                               SRAM_MAX_W'(wmask0), LANE_WIDTH));
  assign w_rd1_dat    = (w_coll && COLL_MODE == COLL_WRITE_FIRST) ? w_rd1_merged : w_rd1_old;

  // Lane-masked array write; the array itself is never reset.
  always_ff @(posedge clk0) begin
    if (w_wr_go) begin
      for (int l = 0; l < NUM_WMASKS; l++) begin
        if (wmask0[l]) r_mem[addr0][l*LANE_WIDTH +: LANE_WIDTH] <= din0[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  sram_rd_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe0 (
    .i_clk   (clk0),
    .i_rst_n (rst_n),
    .i_vld   (w_rd0_en),
    .i_dat   (w_rd0_dat),
    .o_vld   (dout0_valid),
    .o_dat   (dout0)
  );

  // Port 1 carries the collision flag alongside its data so the pulse lines up with the read.
  sram_rd_pipe #(
    .WIDTH   (DATA_WIDTH + 1),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe1 (
    .i_clk   (clk0),
    .i_rst_n (rst_n),
    .i_vld   (w_rd1_en),
    .i_dat   ({w_coll, w_rd1_dat}),
    .o_vld   (dout1_valid),
    .o_dat   (w_p1_dat)
  );

  assign dout1     = w_p1_dat[DATA_WIDTH-1:0];
  assign collision = dout1_valid & w_p1_dat[DATA_WIDTH];

  // Delay the collision event so the counter steps on the same edge the pulse appears (latency 2).
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) r_coll_d <= 1'b0;
    else        r_coll_d <= w_coll;
  end

  assign w_coll_inc = (READ_LATENCY == 1) ? w_coll : r_coll_d;

  // Saturating collision counter; clear beats a coincident increment.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n)                                     r_coll_count <= '0;
    else if (coll_clr)                              r_coll_count <= '0;
    else if (w_coll_inc && r_coll_count != 16'hFFFF) r_coll_count <= r_coll_count + 16'd1;
  end

  assign coll_count = r_coll_count;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Self-checking bench for sram_1rw1r_param: two instances (latency 1 write-first, latency 2 read-first).
// Latency: expectations carry the cycle at which each read must return.
// Backpressure: none; stimulus is driven one request per cycle.
module tb_sram_1rw1r_param;

  typedef struct {
    int          due;
    logic [31:0] dat;
    logic        coll;
  } exp_t;

  logic        clk0 = 1'b0;
  logic        rst_n = 1'b0;
  logic        csb0 = 1'b1;
  logic        web0 = 1'b1;
  logic [3:0]  wmask0 = 4'h0;
  logic [8:0]  addr0 = '0;
  logic [31:0] din0 = '0;
  logic        csb1 = 1'b1;
  logic [8:0]  addr1 = '0;
  logic        coll_clr = 1'b0;

  logic [31:0] a_d0, a_d1, b_d0, b_d1;
  logic        a_v0, a_v1, b_v0, b_v1, a_coll, b_coll;
  logic [15:0] a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];
  exp_t ea0, ea1, eb0, eb1;
  logic [31:0] mdl [512];

  sram_1rw1r_param #(.READ_LATENCY(1), .COLL_MODE(0)) dut_a (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(a_d0), .dout0_valid(a_v0), .csb1(csb1), .addr1(addr1), .dout1(a_d1),
    .dout1_valid(a_v1), .coll_clr(coll_clr), .collision(a_coll), .coll_count(a_cnt));

  sram_1rw1r_param #(.READ_LATENCY(2), .COLL_MODE(1)) dut_b (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(b_d0), .dout0_valid(b_v0), .csb1(csb1), .addr1(addr1), .dout1(b_d1),
    .dout1_valid(b_v1), .coll_clr(coll_clr), .collision(b_coll), .coll_count(b_cnt));

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    if (m[0]) r[7:0]   = n[7:0];
    if (m[1]) r[15:8]  = n[15:8];
    if (m[2]) r[23:16] = n[23:16];
    if (m[3]) r[31:24] = n[31:24];
    return r;
  endfunction

  // Drive one request cycle, record expected returns, update the reference memory.
  task automatic drive(input logic p0, input logic we, input logic [3:0] m, input logic [8:0] a0,
                       input logic [31:0] d0, input logic p1, input logic [8:0] a1);
    logic [31:0] old1;
    logic        coll;
    csb0 = ~p0; web0 = ~we; wmask0 = m; addr0 = a0; din0 = d0; csb1 = ~p1; addr1 = a1;
    coll = p0 && we && (m != 4'h0) && p1 && (a0 == a1);
    if (p0 && !we) begin
      qa0.push_back('{cyc + 1, mdl[a0], 1'b0});
      qb0.push_back('{cyc + 2, mdl[a0], 1'b0});
    end
    if (p1) begin
      old1 = mdl[a1];
      qa1.push_back('{cyc + 1, coll ? merge(old1, d0, m) : old1, coll});
      qb1.push_back('{cyc + 2, old1, coll});
    end
    if (p0 && we) mdl[a0] = merge(mdl[a0], d0, m);
    @(negedge clk0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 9'h0, 32'h0, 1'b0, 9'h0);
  endtask

  // Scoreboard monitors: each valid pops one expectation; an overdue expectation is a miss.
  always @(negedge clk0) if (rst_n) begin
    if (a_v0) begin
      checks++;
      if (qa0.size() == 0) begin errors++; $display("FAIL a_dout0_extra: got %h, required no valid", a_d0); end
      else begin
        ea0 = qa0.pop_front();
        if (a_d0 !== ea0.dat || cyc !== ea0.due) begin
          errors++; $display("FAIL a_dout0: got %h at cyc %0d, required %h at cyc %0d", a_d0, cyc, ea0.dat, ea0.due);
        end
      end
    end else if (qa0.size() != 0 && qa0[0].due <= cyc) begin
      checks++; errors++; ea0 = qa0.pop_front();
      $display("FAIL a_dout0_missing: got no valid at cyc %0d, required %h", cyc, ea0.dat);
    end
  end

  always @(negedge clk0) if (rst_n) begin
    if (a_v1) begin
      checks++;
      if (qa1.size() == 0) begin errors++; $display("FAIL a_dout1_extra: got %h, required no valid", a_d1); end
      else begin
        ea1 = qa1.pop_front();
        if (a_d1 !== ea1.dat || a_coll !== ea1.coll || cyc !== ea1.due) begin
          errors++; $display("FAIL a_dout1: got %h coll=%b cyc %0d, required %h coll=%b cyc %0d",
                             a_d1, a_coll, cyc, ea1.dat, ea1.coll, ea1.due);
        end
      end
    end else begin
      checks++;
      if (a_coll !== 1'b0) begin errors++; $display("FAIL a_coll_idle: got %b, required 0", a_coll); end
      if (qa1.size() != 0 && qa1[0].due <= cyc) begin
        errors++; ea1 = qa1.pop_front();
        $display("FAIL a_dout1_missing: got no valid at cyc %0d, required %h", cyc, ea1.dat);
      end
    end
  end

  always @(negedge clk0) if (rst_n) begin
    if (b_v0) begin
      checks++;
      if (qb0.size() == 0) begin errors++; $display("FAIL b_dout0_extra: got %h, required no valid", b_d0); end
      else begin
        eb0 = qb0.pop_front();
        if (b_d0 !== eb0.dat || cyc !== eb0.due) begin
          errors++; $display("FAIL b_dout0: got %h at cyc %0d, required %h at cyc %0d", b_d0, cyc, eb0.dat, eb0.due);
        end
      end
    end else if (qb0.size() != 0 && qb0[0].due <= cyc) begin
      checks++; errors++; eb0 = qb0.pop_front();
      $display("FAIL b_dout0_missing: got no valid at cyc %0d, required %h", cyc, eb0.dat);
    end
  end

  always @(negedge clk0) if (rst_n) begin
    if (b_v1) begin
      checks++;
      if (qb1.size() == 0) begin errors++; $display("FAIL b_dout1_extra: got %h, required no valid", b_d1); end
      else begin
        eb1 = qb1.pop_front();
        if (b_d1 !== eb1.dat || b_coll !== eb1.coll || cyc !== eb1.due) begin
          errors++; $display("FAIL b_dout1: got %h coll=%b cyc %0d, required %h coll=%b cyc %0d",
                             b_d1, b_coll, cyc, eb1.dat, eb1.coll, eb1.due);
        end
      end
    end else begin
      checks++;
      if (b_coll !== 1'b0) begin errors++; $display("FAIL b_coll_idle: got %b, required 0", b_coll); end
      if (qb1.size() != 0 && qb1[0].due <= cyc) begin
        errors++; eb1 = qb1.pop_front();
        $display("FAIL b_dout1_missing: got no valid at cyc %0d, required %h", cyc, eb1.dat);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk0);
    checks++;
    if ({a_d0, a_d1, a_v0, a_v1, a_coll, a_cnt} !== 83'h0) begin
      errors++; $display("FAIL reset_a: got d0=%h d1=%h v=%b%b coll=%b cnt=%h, required all 0", a_d0, a_d1, a_v0, a_v1, a_coll, a_cnt);
    end
    checks++;
    if ({b_d0, b_d1, b_v0, b_v1, b_coll, b_cnt} !== 83'h0) begin
      errors++; $display("FAIL reset_b: got d0=%h d1=%h v=%b%b coll=%b cnt=%h, required all 0", b_d0, b_d1, b_v0, b_v1, b_coll, b_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk0);
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 4'hF, 9'h010, 32'hDEADBEEF, 1'b0, 9'h0);
    drive(1'b0, 1'b0, 4'h0, 9'h0, 32'h0, 1'b1, 9'h010);
    checks++;
    if (a_v1 !== 1'b1 || a_d1 !== 32'hDEADBEEF || b_v1 !== 1'b0) begin
      errors++; $display("FAIL wr_rd_lat1: got a_v1=%b a_d1=%h b_v1=%b, required 1 deadbeef 0", a_v1, a_d1, b_v1);
    end
    idle(1);
    checks++;
    if (b_v1 !== 1'b1 || b_d1 !== 32'hDEADBEEF || a_v1 !== 1'b0) begin
      errors++; $display("FAIL wr_rd_lat2: got b_v1=%b b_d1=%h a_v1=%b, required 1 deadbeef 0", b_v1, b_d1, a_v1);
    end
    idle(2);
  endtask

  task automatic test_mask();
    drive(1'b1, 1'b1, 4'hF, 9'h020, 32'h11223344, 1'b0, 9'h0);
    drive(1'b1, 1'b1, 4'b0101, 9'h020, 32'hAABBCCDD, 1'b0, 9'h0);
    drive(1'b1, 1'b0, 4'h0, 9'h020, 32'h0, 1'b0, 9'h0);
    checks++;
    if (a_v0 !== 1'b1 || a_d0 !== 32'h11BB33DD) begin
      errors++; $display("FAIL mask_merge: got v=%b d=%h, required 1 11bb33dd", a_v0, a_d0);
    end
    idle(2);
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b1, 4'hF, 9'h030, 32'h0, 1'b0, 9'h0);
    drive(1'b1, 1'b1, 4'hF, 9'h030, 32'hFFFFFFFF, 1'b1, 9'h030);
    checks++;
    if (a_d1 !== 32'hFFFFFFFF || a_coll !== 1'b1 || a_cnt !== 16'd1 || b_cnt !== 16'd0) begin
      errors++; $display("FAIL coll_write_first: got d1=%h coll=%b cnt=%0d bcnt=%0d, required ffffffff 1 1 0", a_d1, a_coll, a_cnt, b_cnt);
    end
    idle(1);
    checks++;
    if (b_d1 !== 32'h0 || b_coll !== 1'b1 || b_cnt !== 16'd1) begin
      errors++; $display("FAIL coll_read_first: got d1=%h coll=%b cnt=%0d, required 0 1 1", b_d1, b_coll, b_cnt);
    end
    idle(2);
  endtask

  task automatic test_zero_mask();
    drive(1'b1, 1'b1, 4'h0, 9'h030, 32'h12345678, 1'b1, 9'h030);
    idle(2);
    checks++;
    if (a_cnt !== 16'd1 || b_cnt !== 16'd1) begin
      errors++; $display("FAIL zero_mask_count: got a=%0d b=%0d, required 1 1", a_cnt, b_cnt);
    end
    drive(1'b1, 1'b0, 4'h0, 9'h030, 32'h0, 1'b0, 9'h0);
    checks++;
    if (a_d0 !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL zero_mask_mem: got %h, required ffffffff", a_d0);
    end
    idle(2);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 70000; i++) drive(1'b1, 1'b1, 4'hF, 9'h040, i, 1'b1, 9'h040);
    checks++;
    if (a_cnt !== 16'hFFFF || b_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL saturate: got a=%h b=%h, required ffff ffff", a_cnt, b_cnt);
    end
    coll_clr = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 9'h040, 32'h0BADF00D, 1'b1, 9'h040);
    checks++;
    if (a_cnt !== 16'h0) begin
      errors++; $display("FAIL clr_wins_a: got %h, required 0", a_cnt);
    end
    idle(1);
    checks++;
    if (a_cnt !== 16'h0 || b_cnt !== 16'h0) begin
      errors++; $display("FAIL clr_wins_b: got a=%h b=%h, required 0 0", a_cnt, b_cnt);
    end
    coll_clr = 1'b0;
    idle(2);
  endtask

  task automatic test_back_to_back();
    int na, nb;
    na = 0; nb = 0;
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'hF, 9'(i), 32'hC0DE0000 | i, 1'b0, 9'h0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'hF, 9'(16 + i), 32'hB0B00000 | i, 1'b1, 9'(i));
      na += int'(a_v1); nb += int'(b_v1);
    end
    for (int i = 0; i < 2; i++) begin
      idle(1);
      na += int'(a_v1); nb += int'(b_v1);
    end
    checks++;
    if (na !== 16 || nb !== 16) begin
      errors++; $display("FAIL stream_pulses: got a=%0d b=%0d, required 16 16", na, nb);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h020; csb1 = 1'b0; addr1 = 9'h030;
    @(posedge clk0);
    #1;
    rst_n = 1'b0;
    csb0 = 1'b1; csb1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk0);
      checks++;
      if ({a_v0, a_v1, b_v0, b_v1, a_coll, b_coll} !== 6'b0 || {a_d0, a_d1, b_d0, b_d1} !== 128'h0) begin
        errors++; $display("FAIL reset_mid: got v=%b%b%b%b d=%h %h %h %h, required all 0",
                           a_v0, a_v1, b_v0, b_v1, a_d0, a_d1, b_d0, b_d1);
      end
    end
    rst_n = 1'b1;
    idle(1);
    drive(1'b1, 1'b0, 4'h0, 9'h020, 32'h0, 1'b1, 9'h020);
    checks++;
    if (a_d0 !== 32'h11BB33DD || a_d1 !== 32'h11BB33DD) begin
      errors++; $display("FAIL mem_retained: got %h %h, required 11bb33dd", a_d0, a_d1);
    end
    idle(3);
  endtask

  initial begin
    @(negedge clk0);
    test_reset();
    test_write_read();
    test_mask();
    test_collision();
    test_zero_mask();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (qa0.size() != 0 || qa1.size() != 0 || qb0.size() != 0 || qb1.size() != 0) begin
      errors++; $display("FAIL drain: got %0d %0d %0d %0d pending, required 0", qa0.size(), qa1.size(), qb0.size(), qb1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
